rr_lock_arbiter: RTL

Registered round-robin arbiter with grant locking. It shares one resource, such as a bus port or datapath unit, among three requesters. A requester keeps its grant for as long as it holds its request high. A hold-timeout revokes the grant from a requester that stalls the resource. The block sits between the requesting masters and the shared resource's select/enable inputs, and replaces fixed-priority combinational grant decoding.

---
 rtl/rr_lock_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rr_lock_arbiter.sv
// Three-way round-robin arbiter with grant locking, a hold timeout and a
// one-cycle cooldown gap between owners. All outputs are registered.
module rr_lock_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic [1:0] {StIdle, StGrant, StCooldown} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;

    logic [1:0]         win_idx;
    logic               any_req;
    logic               owner_req;
    logic               hold_expired;

    assign any_req      = |request;
    assign owner_req    = request[last_q];
    assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Scan starts just after the previous owner so it becomes lowest priority.
    always_comb begin
        win_idx = 2'd0;
        unique case (last_q)
            2'd0: begin
                if (request[1])      win_idx = 2'd1;
                else if (request[2]) win_idx = 2'd2;
                else                 win_idx = 2'd0;
            end
            2'd1: begin
                if (request[2])      win_idx = 2'd2;
                else if (request[0]) win_idx = 2'd0;
                else                 win_idx = 2'd1;
            end
            default: begin
                if (request[0])      win_idx = 2'd0;
                else if (request[1]) win_idx = 2'd1;
                else                 win_idx = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 2'd2;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (any_req) state_d = StGrant;
            StGrant:    if (!owner_req || hold_expired) state_d = StCooldown;
            StCooldown: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Release is tested before expiry so a coinciding drop never flags timeout.
    always_comb begin
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    grant_id_d       = win_idx;
                    busy_d           = 1'b1;
                    last_d           = win_idx;
                    cnt_d            = '0;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    grant_d    = '0;
                    grant_id_d = 2'd0;
                    busy_d     = 1'b0;
                end else if (hold_expired) begin
                    grant_d    = '0;
                    grant_id_d = 2'd0;
                    busy_d     = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCooldown: begin
                grant_d    = '0;
                grant_id_d = 2'd0;
                busy_d     = 1'b0;
                timeout_d  = 1'b0;
            end
            default: begin
                grant_d    = '0;
                grant_id_d = 2'd0;
                busy_d     = 1'b0;
                timeout_d  = 1'b0;
            end
        endcase
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule
